pipe_hazard_scoreboard: RTL

Issue controller for the three-stage register-file pipeline. It sits in front of the Stage 1 decode register. It accepts one decoded instruction per cycle through a valid/ready handshake and tracks which destination registers have writes in flight. It holds back any instruction with a RAW or WAW hazard until the conflicting write has retired from the final pipeline stage.

---
 rtl/pipe_hazard_scoreboard_pkg.sv | 13 +
 rtl/pipe_wb_delay_line.sv | 42 ++++
 rtl/pipe_hazard_scoreboard.sv | 95 +++++++++
 3 files changed

// File: rtl/pipe_hazard_scoreboard_pkg.sv
// Shared constants and the delay-line tag type for the pipeline issue scoreboard.
// The tag width follows SEL_W here; the top's SEL_W/NREG parameters must keep these defaults.
package pipe_hazard_scoreboard_pkg;

    localparam int SEL_W = 5;
    localparam int NREG  = 2 ** SEL_W;

    typedef struct packed {
        logic             valid;
        logic [SEL_W-1:0] rd;
    } wb_tag_t;

endpackage

// File: rtl/pipe_wb_delay_line.sv
// WB_LATENCY-deep shift of write-back tags; the last stage is the retiring write.
// Synchronous clear on rst or flush empties every stage.
module pipe_wb_delay_line
    import pipe_hazard_scoreboard_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    clear,
    input  wb_tag_t in_tag,
    output wb_tag_t out_tag,
    output logic    any_valid
);

    wb_tag_t line [DEPTH];

    // NOTE: every stage is reset, not just the valid bits, so retire_sel reads 0 after reset.
    // NOTE: non-blocking assignments make all stages shift from their pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                line[i] <= '0;
            end
        end else begin
            line[0] <= in_tag;
            for (int k = 1; k < DEPTH; k++) begin
                line[k] <= line[k-1];
            end
        end
    end

    assign out_tag = line[DEPTH-1];

    always_comb begin
        any_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            any_valid = any_valid | line[i].valid;
        end
    end

endmodule

// File: rtl/pipe_hazard_scoreboard.sv
// Issue controller: holds back RAW/WAW hazards until the conflicting write retires.
// Optional counters: define PIPE_SCOREBOARD_STATS_EN to add stall_count and issue_count.
module pipe_hazard_scoreboard #(
    parameter int NREG       = pipe_hazard_scoreboard_pkg::NREG,
    parameter int SEL_W      = pipe_hazard_scoreboard_pkg::SEL_W,
    parameter int WB_LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [SEL_W-1:0] in_rs1,
    input  logic [SEL_W-1:0] in_rs2,
    input  logic [SEL_W-1:0] in_rd,
    input  logic             in_we,
    input  logic             flush,
    output logic             in_ready,
    output logic             issue,
    output logic             retire_valid,
    output logic [SEL_W-1:0] retire_sel,
    output logic [NREG-1:0]  pending,
    output logic             busy
`ifdef PIPE_SCOREBOARD_STATS_EN
    ,
    output logic [31:0]      stall_count,
    output logic [31:0]      issue_count
`endif
);

    import pipe_hazard_scoreboard_pkg::wb_tag_t;

    logic            hazard;
    logic [NREG-1:0] pending_nxt;
    wb_tag_t         new_tag;
    wb_tag_t         last_tag;

    // A retiring register still counts as pending this cycle, so no bypass from retirement.
    assign hazard   = in_valid & (pending[in_rs1] | pending[in_rs2] | (in_we & pending[in_rd]));
    assign in_ready = ~rst & ~flush & ~hazard;
    assign issue    = in_valid & in_ready;

    assign new_tag.valid = issue & in_we;
    assign new_tag.rd    = in_rd;

    pipe_wb_delay_line #(
        .DEPTH (WB_LATENCY)
    ) u_delay (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush),
        .in_tag    (new_tag),
        .out_tag   (last_tag),
        .any_valid (busy)
    );

    assign retire_valid = last_tag.valid;
    assign retire_sel   = last_tag.rd;

    // NOTE: default assignment first keeps this combinational block latch-free.
    always_comb begin
        pending_nxt = pending;
        if (retire_valid) begin
            pending_nxt[retire_sel] = 1'b0;
        end
        // Set after clear: a new write to the retiring register keeps its bit high.
        if (issue && in_we && (in_rd != '0)) begin
            pending_nxt[in_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

`ifdef PIPE_SCOREBOARD_STATS_EN
    // Counters survive flush and saturate rather than wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
            issue_count <= '0;
        end else begin
            if (in_valid && !in_ready && !flush && (stall_count != '1)) begin
                stall_count <= stall_count + 32'd1;
            end
            if (issue && (issue_count != '1)) begin
                issue_count <= issue_count + 32'd1;
            end
        end
    end
`endif

endmodule
